// File: rtl/tx_arbiter_pkg.sv
// Shared types and helpers for the host transmit arbiter.
// The optional grant header is enabled by defining TX_ARBITER_HEADER_EN.
package tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_LOAD,
        ST_SHIFT,
        ST_WAIT
    } state_e;

    localparam logic [3:0]  HDR_TAG = 4'hA;
    localparam int unsigned RR_MAX  = 8;

    // First set bit of vld scanning upward from ptr, wrapping at n; returns ptr if none set.
    function automatic logic [2:0] rr_next_grant(input logic [RR_MAX-1:0] vld,
                                                 input logic [2:0]        ptr,
                                                 input int unsigned       n);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (k < n) && vld[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tx_arbiter_rr_picker.sv
// Combinational round-robin selection: first valid requester at or after the pointer.
module rr_picker
    import tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [GW-1:0]   ptr_i,
    output logic [GW-1:0]   pick_c_o,
    output logic            any_c_o
);

    assign pick_c_o = GW'(rr_next_grant(RR_MAX'(valid_i), 3'(ptr_i), NREQ));
    assign any_c_o  = |valid_i;

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin, packet-locked arbiter serialising requester words MSB-first onto a byte channel.
// Define TX_ARBITER_HEADER_EN to prefix every grant with a {HDR_TAG, grant_id} byte.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned WORD_W        = 32,
    parameter int unsigned MAX_BURST     = 16,
    parameter int unsigned STALL_TIMEOUT = 255
) (
    input  logic                      clk_100,
    input  logic                      nrst,
    input  logic [NREQ*WORD_W-1:0]    req_data,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           req_ready,
    output logic [7:0]                tx_byte,
    output logic                      tx_valid,
    input  logic                      tx_full_n,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic                      stall_err
);

    localparam int unsigned GW  = $clog2(NREQ);
    localparam int unsigned NB  = WORD_W / 8;
    localparam int unsigned BCW = $clog2(MAX_BURST + 1);
    localparam int unsigned SCW = $clog2(STALL_TIMEOUT + 1);
    localparam int unsigned RW  = $clog2(NB + 1);
`ifdef TX_ARBITER_HEADER_EN
    localparam int unsigned SH_W = WORD_W + 8;
`else
    localparam int unsigned SH_W = WORD_W;
`endif

    state_e            state_q;
    logic [GW-1:0]     grant_q;
    logic [GW-1:0]     rr_q;
    logic [BCW-1:0]    burst_q;
    logic [SCW-1:0]    stall_q;
    logic [SH_W-1:0]   sh_q;
    logic [RW-1:0]     rem_q;
    logic              last_q;
    logic [NREQ-1:0]   req_ready_q;
    logic              tx_valid_q;
    logic              busy_q;
    logic              stall_err_q;

    logic [GW-1:0]     pick_c;
    logic              any_c;
    logic [GW-1:0]     rr_adv_c;
    logic              gv_c;
    logic              xfer_c;
    logic [WORD_W-1:0] word_c;
    logic [SH_W-1:0]   load_c;
    logic [RW-1:0]     load_rem_c;
    logic [WORD_W-1:0] words_c [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_words
        assign words_c[i] = req_data[i*WORD_W +: WORD_W];
    end

    rr_picker #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_rr_picker (
        .valid_i  (req_valid),
        .ptr_i    (rr_q),
        .pick_c_o (pick_c),
        .any_c_o  (any_c)
    );

    assign word_c   = words_c[grant_q];
    assign gv_c     = req_valid[grant_q];
    assign xfer_c   = tx_valid_q & tx_full_n;
    assign rr_adv_c = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);

`ifdef TX_ARBITER_HEADER_EN
    logic hdr_pend_q;

    // First word of a grant is loaded behind its header byte.
    assign load_c     = hdr_pend_q ? {HDR_TAG, 4'(grant_q), word_c} : {word_c, 8'h00};
    assign load_rem_c = hdr_pend_q ? RW'(NB) : RW'(NB - 1);

    always_ff @(posedge clk_100 or negedge nrst) begin
        if (!nrst) begin
            hdr_pend_q <= 1'b0;
        end else if (state_q == ST_ARB && any_c) begin
            hdr_pend_q <= 1'b1;
        end else if (state_q == ST_LOAD) begin
            hdr_pend_q <= 1'b0;
        end
    end
`else
    assign load_c     = word_c;
    assign load_rem_c = RW'(NB - 1);
`endif

    // req_ready is registered, so the accept decision for a LOAD cycle is taken on entry;
    // requesters keep valid asserted until their word is accepted.
    always_ff @(posedge clk_100 or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            burst_q     <= '0;
            stall_q     <= '0;
            sh_q        <= '0;
            rem_q       <= '0;
            last_q      <= 1'b0;
            req_ready_q <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            stall_err_q <= 1'b0;
        end else begin
            req_ready_q <= '0;
            stall_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        state_q <= ST_ARB;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (any_c) begin
                        grant_q     <= pick_c;
                        burst_q     <= '0;
                        req_ready_q <= NREQ'(1) << pick_c;
                        state_q     <= ST_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    sh_q       <= load_c;
                    rem_q      <= load_rem_c;
                    last_q     <= req_last[grant_q];
                    tx_valid_q <= 1'b1;
                    burst_q    <= burst_q + BCW'(1);
                    stall_q    <= '0;
                    state_q    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (xfer_c) begin
                        if (rem_q != '0) begin
                            sh_q  <= sh_q << 8;
                            rem_q <= rem_q - RW'(1);
                        end else begin
                            tx_valid_q <= 1'b0;
                            if (last_q || burst_q == BCW'(MAX_BURST)) begin
                                rr_q    <= rr_adv_c;
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end else if (gv_c) begin
                                req_ready_q <= NREQ'(1) << grant_q;
                                state_q     <= ST_LOAD;
                            end else begin
                                state_q <= ST_WAIT;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (gv_c) begin
                        req_ready_q <= NREQ'(1) << grant_q;
                        state_q     <= ST_LOAD;
                    end else if (stall_q == SCW'(STALL_TIMEOUT - 1)) begin
                        stall_err_q <= 1'b1;
                        rr_q        <= rr_adv_c;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        stall_q <= stall_q + SCW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign tx_byte   = sh_q[SH_W-1 -: 8];
    assign tx_valid  = tx_valid_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign stall_err = stall_err_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed self-checking bench for tx_arbiter (header checks only when TX_ARBITER_HEADER_EN is defined).
module tb_tx_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned WORD_W = 32;

    logic                   clk_100 = 1'b0;
    logic                   nrst    = 1'b0;
    logic [NREQ*WORD_W-1:0] req_data = '0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_last = '0;
    logic [NREQ-1:0]        req_ready;
    logic [7:0]             tx_byte;
    logic                   tx_valid;
    logic                   tx_full_n = 1'b1;
    logic [1:0]             grant_id;
    logic                   busy;
    logic                   stall_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0]     src_q [NREQ][$];
    bit              src_l [NREQ][$];
    logic [7:0]      rx_q [$];
    logic [7:0]      exp_q [$];
    int              rdy_log [$];
    int              prot_err;
    int              cyc;
    int              stall_seen;
    int              stall_cyc;
    int              last_tx_cyc;
    logic            stall_busy;
    logic [NREQ-1:0] prev_ready;

    tx_arbiter #(
        .NREQ          (NREQ),
        .WORD_W        (WORD_W),
        .MAX_BURST     (16),
        .STALL_TIMEOUT (255)
    ) dut (
        .clk_100   (clk_100),
        .nrst      (nrst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_full_n (tx_full_n),
        .grant_id  (grant_id),
        .busy      (busy),
        .stall_err (stall_err)
    );

    always #5 clk_100 = ~clk_100;

    task automatic apply_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]                 = 1'b1;
                req_data[i*WORD_W +: WORD_W] = src_q[i][0];
                req_last[i]                  = src_l[i][0];
            end else begin
                req_valid[i]                 = 1'b0;
                req_data[i*WORD_W +: WORD_W] = '0;
                req_last[i]                  = 1'b0;
            end
        end
    endtask

    // Sample the current cycle, then advance one clock and present the requesters' next words.
    task automatic tick();
        if (tx_valid === 1'b1 && tx_full_n === 1'b1) begin
            rx_q.push_back(tx_byte);
            last_tx_cyc = cyc;
        end
        if (stall_err === 1'b1) begin
            stall_seen++;
            stall_cyc  = cyc;
            stall_busy = busy;
        end
        if (req_ready != '0) begin
            if (!$onehot(req_ready) || req_ready != (NREQ'(1) << grant_id) || prev_ready != '0)
                prot_err++;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    rdy_log.push_back(i);
                    if (src_q[i].size() > 0) begin
                        void'(src_q[i].pop_front());
                        void'(src_l[i].pop_front());
                    end else begin
                        prot_err++;
                    end
                end
            end
        end
        prev_ready = req_ready;
        @(posedge clk_100);
        #1;
        cyc++;
        apply_inputs();
    endtask

    task automatic do_reset();
        nrst      = 1'b0;
        tx_full_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            src_q[i].delete();
            src_l[i].delete();
        end
        rx_q.delete();
        exp_q.delete();
        rdy_log.delete();
        prot_err    = 0;
        stall_seen  = 0;
        stall_cyc   = 0;
        last_tx_cyc = 0;
        stall_busy  = 1'b0;
        prev_ready  = '0;
        apply_inputs();
        repeat (2) @(posedge clk_100);
        #1;
        nrst = 1'b1;
        cyc  = 0;
    endtask

    task automatic exp_grant(input int id);
`ifdef TX_ARBITER_HEADER_EN
        exp_q.push_back({4'hA, 4'(id)});
`else
        if (id < 0) exp_q.push_back(8'h00);
`endif
    endtask

    task automatic exp_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    function automatic int byte_diff(input logic [7:0] a [$], input logic [7:0] b [$]);
        int n;
        n = (a.size() > b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) begin
            if (i >= a.size() || i >= b.size()) return i;
            if (a[i] !== b[i]) return i;
        end
        return -1;
    endfunction

    function automatic int int_diff(input int a [$], input int b [$]);
        int n;
        n = (a.size() > b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) begin
            if (i >= a.size() || i >= b.size()) return i;
            if (a[i] != b[i]) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL reset_stall_err got=%b exp=0", stall_err); end
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        do_reset();
        src_q[0].push_back(32'hDEADBEEF); src_l[0].push_back(1'b1);
        exp_grant(0); exp_word(32'hDEADBEEF);
        apply_inputs();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_c0_busy got=%b exp=0", busy); end
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_c1_busy got=%b exp=1", busy); end
        tick();
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_c2_ready got=%b exp=0001", req_ready); end
        tick();
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_byte !== exp_q[k]) begin
                failures++;
                $display("FAIL single_byte%0d got valid=%b byte=%h exp valid=1 byte=%h", k, tx_valid, tx_byte, exp_q[k]);
            end
            tick();
        end
        checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin failures++; $display("FAIL single_done got busy=%b valid=%b exp 0 0", busy, tx_valid); end
        checks++; if (prot_err != 0) begin failures++; $display("FAIL single_protocol got=%0d exp=0", prot_err); end
    endtask

    task automatic test_round_robin();
        int          exp_ids [$];
        int          d;
        logic [31:0] w;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NREQ; i++) begin
                w = {8'(16 * i + p), 8'hC3, 8'(i), 8'(p)};
                src_q[i].push_back(w); src_l[i].push_back(1'b1);
                exp_grant(i); exp_word(w); exp_ids.push_back(i);
            end
        end
        apply_inputs();
        for (int n = 0; n < 300 && rx_q.size() < exp_q.size(); n++) tick();
        checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL rr_timeout got=%0d bytes exp=%0d", rx_q.size(), exp_q.size()); end
        d = int_diff(rdy_log, exp_ids);
        checks++; if (d != -1) begin failures++; $display("FAIL rr_grant_order at=%0d got_len=%0d exp_len=%0d", d, rdy_log.size(), exp_ids.size()); end
        d = byte_diff(rx_q, exp_q);
        checks++; if (d != -1) begin failures++; $display("FAIL rr_bytes at=%0d got_len=%0d exp_len=%0d", d, rx_q.size(), exp_q.size()); end
        checks++; if (prot_err != 0) begin failures++; $display("FAIL rr_protocol got=%0d exp=0", prot_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        logic [7:0] tgt;
        int         held;
        int         d;
        do_reset();
        src_q[0].push_back(32'h11223344); src_l[0].push_back(1'b1);
        exp_grant(0); exp_word(32'h11223344);
        tgt  = exp_q[2];
        held = 0;
        apply_inputs();
        for (int n = 0; n < 60 && rx_q.size() < exp_q.size(); n++) begin
            if (tx_valid === 1'b1 && rx_q.size() == 2 && held < 5) begin
                tx_full_n = 1'b0;
                held++;
                checks++;
                if (tx_byte !== tgt) begin failures++; $display("FAIL bp_hold%0d got=%h exp=%h", held, tx_byte, tgt); end
            end else begin
                tx_full_n = 1'b1;
            end
            tick();
        end
        tx_full_n = 1'b1;
        repeat (3) tick();
        checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
        d = byte_diff(rx_q, exp_q);
        checks++; if (d != -1) begin failures++; $display("FAIL bp_bytes at=%0d got_len=%0d exp_len=%0d", d, rx_q.size(), exp_q.size()); end
    endtask

    task automatic test_burst_cap();
        int          exp_ids [$];
        int          d;
        logic [31:0] w;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            src_q[1].push_back(32'h1000_0000 + 32'(k)); src_l[1].push_back(k == 19);
        end
        src_q[2].push_back(32'h2222_0000); src_l[2].push_back(1'b1);
        exp_grant(1);
        for (int k = 0; k < 16; k++) begin
            w = 32'h1000_0000 + 32'(k); exp_word(w); exp_ids.push_back(1);
        end
        exp_grant(2); exp_word(32'h2222_0000); exp_ids.push_back(2);
        exp_grant(1);
        for (int k = 16; k < 20; k++) begin
            w = 32'h1000_0000 + 32'(k); exp_word(w); exp_ids.push_back(1);
        end
        apply_inputs();
        for (int n = 0; n < 600 && rx_q.size() < exp_q.size(); n++) tick();
        checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL burst_timeout got=%0d bytes exp=%0d", rx_q.size(), exp_q.size()); end
        checks++; if (rdy_log.size() <= 16 || rdy_log[16] != 2) begin failures++; $display("FAIL burst_handover got_len=%0d exp grant 2 at word 17", rdy_log.size()); end
        d = int_diff(rdy_log, exp_ids);
        checks++; if (d != -1) begin failures++; $display("FAIL burst_grant_order at=%0d got_len=%0d exp_len=%0d", d, rdy_log.size(), exp_ids.size()); end
        d = byte_diff(rx_q, exp_q);
        checks++; if (d != -1) begin failures++; $display("FAIL burst_bytes at=%0d got_len=%0d exp_len=%0d", d, rx_q.size(), exp_q.size()); end
        checks++; if (prot_err != 0) begin failures++; $display("FAIL burst_protocol got=%0d exp=0", prot_err); end
    endtask

    task automatic test_stall_timeout();
        int d;
        do_reset();
        src_q[3].push_back(32'h3C3C5A5A); src_l[3].push_back(1'b0);
        exp_grant(3); exp_word(32'h3C3C5A5A);
        apply_inputs();
        for (int n = 0; n < 20 && rdy_log.size() == 0; n++) tick();
        src_q[0].push_back(32'h0BADF00D); src_l[0].push_back(1'b1);
        exp_grant(0); exp_word(32'h0BADF00D);
        apply_inputs();
        for (int n = 0; n < 400 && stall_seen == 0; n++) tick();
        checks++; if (stall_seen != 1) begin failures++; $display("FAIL stall_pulse got=%0d exp=1", stall_seen); end
        checks++; if (stall_cyc - last_tx_cyc != 256) begin failures++; $display("FAIL stall_delay got=%0d exp=256", stall_cyc - last_tx_cyc); end
        checks++; if (stall_busy !== 1'b0) begin failures++; $display("FAIL stall_busy got=%b exp=0", stall_busy); end
        checks++; if (rdy_log.size() != 1) begin failures++; $display("FAIL stall_held_grant got=%0d readies exp=1", rdy_log.size()); end
        for (int n = 0; n < 60 && rx_q.size() < exp_q.size(); n++) tick();
        checks++; if (rdy_log.size() != 2 || rdy_log[rdy_log.size()-1] != 0) begin failures++; $display("FAIL stall_next_grant got_len=%0d exp grant 0 second", rdy_log.size()); end
        d = byte_diff(rx_q, exp_q);
        checks++; if (d != -1) begin failures++; $display("FAIL stall_bytes at=%0d got_len=%0d exp_len=%0d", d, rx_q.size(), exp_q.size()); end
        checks++; if (stall_seen != 1) begin failures++; $display("FAIL stall_single got=%0d exp=1", stall_seen); end
        checks++; if (prot_err != 0) begin failures++; $display("FAIL stall_protocol got=%0d exp=0", prot_err); end
    endtask

    task automatic test_reset_midword();
        do_reset();
        src_q[1].push_back(32'hCAFEF00D); src_l[1].push_back(1'b1);
        apply_inputs();
        repeat (4) tick();
        checks++; if (tx_valid !== 1'b1 || grant_id !== 2'd1) begin failures++; $display("FAIL midrst_active got valid=%b grant=%0d exp 1 1", tx_valid, grant_id); end
        nrst = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0 || tx_byte !== 8'h00) begin failures++; $display("FAIL midrst_tx got valid=%b byte=%h exp 0 00", tx_valid, tx_byte); end
        checks++; if (busy !== 1'b0 || grant_id !== 2'd0 || req_ready !== '0) begin failures++; $display("FAIL midrst_ctrl got busy=%b grant=%0d ready=%b exp 0 0 0000", busy, grant_id, req_ready); end
        src_q[1].delete(); src_l[1].delete();
        apply_inputs();
        @(posedge clk_100);
        #1;
        nrst = 1'b1;
        repeat (3) tick();
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_discard got valid=%b busy=%b exp 0 0", tx_valid, busy); end
    endtask

`ifdef TX_ARBITER_HEADER_EN
    task automatic test_header();
        logic [7:0] hexp [$];
        int         d;
        hexp = '{8'hA2, 8'h01, 8'h02, 8'h03, 8'h04};
        do_reset();
        src_q[2].push_back(32'h01020304); src_l[2].push_back(1'b1);
        apply_inputs();
        for (int n = 0; n < 40 && rx_q.size() < hexp.size(); n++) tick();
        d = byte_diff(rx_q, hexp);
        checks++; if (d != -1) begin failures++; $display("FAIL header_bytes at=%0d got_len=%0d exp_len=%0d", d, rx_q.size(), hexp.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_burst_cap();
        test_stall_timeout();
        test_reset_midword();
`ifdef TX_ARBITER_HEADER_EN
        test_header();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
